ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 138 +++++++++++++
 tb/tb_ps2_host_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Define PS2_TX_TIMEOUT_EN to abort a frame the device never finishes clocking.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 850000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, STOP, ACK, WAIT_IDLE} state_t;
    localparam int IW = $clog2(INHIBIT_CYC + 1);

    state_t        r_state, w_next;
    logic [IW-1:0] r_inh_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_data;
    logic          r_parity;
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    logic [8:0]    w_frame;
    logic          w_bit, w_fall, w_clk, w_dat, w_inh_last, w_accept, w_timeout;

    assign w_clk      = r_clk_sync[1];
    assign w_dat      = r_dat_sync[1];
    assign w_fall     = r_clk_prev & ~w_clk;
    assign w_frame    = {r_parity, r_data};
    assign w_bit      = w_frame[r_bit_cnt];
    assign w_inh_last = r_inh_cnt == IW'(INHIBIT_CYC - 1);
    assign tx_ready   = KEY0 && r_state == IDLE;
    assign tx_busy    = ~tx_ready;
    assign w_accept   = tx_valid & tx_ready;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            r_state    <= IDLE;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            r_clk_prev <= w_clk;
            r_inh_cnt  <= (r_state == INHIBIT) ? r_inh_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_data   <= tx_data;
                r_parity <= ~^tx_data;
            end
            // index 8 (parity) is the last bit driven; the next edge moves to STOP
            if (r_state == START)
                r_bit_cnt <= '0;
            else if (r_state == BITS && w_fall && r_bit_cnt != 4'd8)
                r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_to_active;
    assign w_to_active = r_state inside {START, BITS, STOP, ACK, WAIT_IDLE};
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0)
            r_to_cnt <= '0;
        else
            r_to_cnt <= w_to_active ? r_to_cnt + 1'b1 : '0;
    end
    assign w_timeout = w_to_active && r_to_cnt == TW'(TIMEOUT_CYC);
`else
    // never fires: the device may hold the bus indefinitely
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        w_next     = r_state;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        case (r_state)
            IDLE:      if (w_accept) w_next = INHIBIT;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = w_inh_last;
                if (w_inh_last) w_next = START;
            end
            START: begin
                ps2_dat_oe = 1'b1;
                if (w_fall) w_next = BITS;
            end
            BITS: begin
                ps2_dat_oe = ~w_bit;
                if (w_fall && r_bit_cnt == 4'd8) w_next = STOP;
            end
            STOP:      w_next = ACK;
            ACK: begin
                if (w_fall) begin
                    tx_err = w_dat;
                    w_next = w_dat ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk && w_dat) begin
                    tx_done = 1'b1;
                    w_next  = IDLE;
                end
            end
            default:   w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next     = IDLE;
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
            tx_done    = 1'b0;
            tx_err     = 1'b1;
        end
        if (!KEY0) begin
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
            tx_done    = 1'b0;
            tx_err     = 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model and a frame scoreboard.
module tb_ps2_host_tx;
    localparam int H   = 20;
    localparam int TO  = 2000;
    localparam int INH = 5000;

    logic       clk = 1'b0;
    logic       key0 = 1'b0;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe, tx_ready, tx_busy, tx_done, tx_err;
    logic       w_ps2_clk, w_ps2_dat;

    assign w_ps2_clk = ~ps2_clk_oe & dev_clk;
    assign w_ps2_dat = ~ps2_dat_oe & dev_dat;

    always #10 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .CLOCK_50(clk), .KEY0(key0), .PS2_CLK(w_ps2_clk), .PS2_DAT(w_ps2_dat),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    int n_pass = 0, n_total = 0;
    int n_done = 0, n_err = 0, n_both = 0;
    logic [9:0] exp_q[$];
    logic [9:0] cap, exp_w;
    int   lo_cnt, dat_first, res, snap_done, snap_err, t_err;
    logic start_ok, rdy_after;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        if (tx_done && tx_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d);
        chk("ready_before_send", {31'b0, tx_ready}, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, ~^d, d});
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // counts inhibit cycles; returns at the first negedge after the clock is released
    task automatic dev_inhibit();
        lo_cnt = 0;
        dat_first = 0;
        for (int k = 0; k < 100 && !ps2_clk_oe; k++) @(negedge clk);
        for (int k = 0; k < 20000 && ps2_clk_oe; k++) begin
            lo_cnt++;
            if (ps2_dat_oe && dat_first == 0) dat_first = lo_cnt;
            @(negedge clk);
        end
    endtask

    task automatic dev_bits(input int n);
        for (int i = 0; i < n; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            cap[i] = w_ps2_dat;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic dev_ack(input logic ack);
        dev_dat = ~ack;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        res = 0;
        rdy_after = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (res != 0) begin
                rdy_after = tx_ready;
                break;
            end
            if (tx_done) res = 1;
            else if (tx_err) res = 2;
            if (k == H) dev_clk = 1'b1;
            if (k == H + 2) dev_dat = 1'b1;
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic dev_frame(input logic ack, input string tag);
        cap = 'x;
        dev_inhibit();
        repeat (H) @(negedge clk);
        start_ok = w_ps2_clk === 1'b1 && w_ps2_dat === 1'b0;
        dev_bits(10);
        dev_ack(ack);
        exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        chk({tag, "_inhibit_len"}, lo_cnt, INH);
        chk({tag, "_dat_oe_last_inhibit"}, dat_first, INH);
        chk({tag, "_start_bit"}, {31'b0, start_ok}, 1);
        chk({tag, "_frame"}, {22'b0, cap}, {22'b0, exp_w});
        chk({tag, "_result"}, res, ack ? 1 : 2);
        chk({tag, "_ready_after"}, {31'b0, rdy_after}, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, tx_ready}, 0);
        chk("rst_busy", {31'b0, tx_busy}, 1);
        chk("rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
        chk("rst_pulses", {30'b0, tx_done, tx_err}, 0);
        key0 = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, tx_ready}, 1);
        chk("post_rst_busy", {31'b0, tx_busy}, 0);

        snap_done = n_done;
        send(8'hED);
        dev_frame(1'b1, "ed");
        chk("ed_bits_const", {22'b0, cap}, 32'h3ED);
        chk("ed_done_once", n_done - snap_done, 1);

        send(8'h01);
        dev_frame(1'b1, "x01");
        chk("x01_parity", {31'b0, cap[8]}, 0);
        send(8'h00);
        dev_frame(1'b1, "x00");
        chk("x00_parity", {31'b0, cap[8]}, 1);
        chk("x00_stop", {31'b0, cap[9]}, 1);

        snap_done = n_done;
        snap_err = n_err;
        send(8'h3C);
        dev_frame(1'b0, "nack");
        chk("nack_err_once", n_err - snap_err, 1);
        chk("nack_no_done", n_done - snap_done, 0);

        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, ~^8'hAA, 8'hAA});
        @(negedge clk);
        tx_data = 8'hF4;
        exp_q.push_back({1'b1, ~^8'hF4, 8'hF4});
        dev_frame(1'b1, "held_aa");
        @(negedge clk);
        chk("f4_accepted_ready", {31'b0, tx_ready}, 0);
        chk("f4_accepted_inhibit", {31'b0, ps2_clk_oe}, 1);
        tx_valid = 1'b0;
        dev_frame(1'b1, "held_f4");

        snap_err = n_err;
        send(8'h12);
        dev_inhibit();
        void'(exp_q.pop_front());
`ifdef PS2_TX_TIMEOUT_EN
        t_err = -1;
        for (int k = 0; k <= TO + 10; k++) begin
            if (tx_err) begin
                t_err = k;
                break;
            end
            @(negedge clk);
        end
        chk("timeout_cycle", t_err, TO);
        @(negedge clk);
        chk("timeout_released", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
        chk("timeout_ready", {31'b0, tx_ready}, 1);
`else
        repeat (TO + 500) @(negedge clk);
        chk("stall_busy", {31'b0, tx_busy}, 1);
        chk("stall_no_err", n_err - snap_err, 0);
`endif
        key0 = 1'b0;
        @(negedge clk);
        key0 = 1'b1;
        @(negedge clk);

        snap_done = n_done;
        snap_err = n_err;
        send(8'hA5);
        dev_inhibit();
        repeat (H) @(negedge clk);
        dev_bits(4);
        exp_w = exp_q.pop_front();
        chk("abort_partial_bits", {28'b0, cap[3:0]}, {28'b0, exp_w[3:0]});
        chk("abort_dat_driven", {31'b0, ps2_dat_oe}, 1);
        key0 = 1'b0;
        @(negedge clk);
        chk("abort_oe_released", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
        repeat (2) @(negedge clk);
        chk("abort_ready_in_rst", {31'b0, tx_ready}, 0);
        key0 = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, tx_ready}, 1);
        chk("abort_no_pulses", (n_done - snap_done) + (n_err - snap_err), 0);

        send(8'hFF);
        dev_frame(1'b1, "ff");
        chk("ff_bits_const", {22'b0, cap}, 32'h3FF);
        chk("never_done_and_err", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
